sysarray_result_drain: RTL and testbench



---
 rtl/sysarray_result_drain.sv | 145 ++++++++++++++
 tb/tb_sysarray_result_drain.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sysarray_result_drain.sv
// Output-side collector for the systolic array: de-skews the time-staggered
// column sums into aligned rows, queues them in a show-ahead FIFO and drains them via valid/ready.
module sysarray_result_drain #(
  parameter int row_width  = 4,
  parameter int fifo_depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*row_width-1:0] mac_in,
  input  logic                   start,
  input  logic [7:0]             num_rows,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [8*row_width-1:0] res_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int aw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cw = $clog2(fifo_depth) + 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                  state_reg;
  logic [7:0]              n_reg;
  logic [15:0]             cnt_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [8*row_width-1:0]  aligned;
  logic                    push_req;
  logic [15:0]             last_cnt;

  // Column i waits row_width-1-i cycles so every column lines up with the last one.
  for (genvar gi = 0; gi < row_width; gi++) begin : g_col
    localparam int depth = row_width - 1 - gi;
    if (depth == 0) begin : g_direct
      assign aligned[8*gi +: 8] = mac_in[8*gi +: 8];
    end else begin : g_dly
      logic [7:0] dly_reg [depth];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < depth; j++) dly_reg[j] <= '0;
        end else begin
          dly_reg[0] <= mac_in[8*gi +: 8];
          for (int j = 1; j < depth; j++) dly_reg[j] <= dly_reg[j-1];
        end
      end
      assign aligned[8*gi +: 8] = dly_reg[depth-1];
    end
  end

  // cnt_reg equals (cycle - t0 - 1); aligned rows start once cnt reaches row_width-1.
  assign push_req = (state_reg == COLLECT) && (cnt_reg >= 16'(row_width - 1));
  assign last_cnt = 16'(n_reg) + 16'(row_width) - 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && (num_rows != 8'd0)) begin
            state_reg <= COLLECT;
            n_reg     <= num_rows;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        COLLECT: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (push_req && (cnt_reg == last_cnt)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [8*row_width-1:0] mem [fifo_depth];
  logic [aw-1:0]          wr_ptr_reg;
  logic [aw-1:0]          rd_ptr_reg;
  logic [cw-1:0]          count_reg;
  logic [cw-1:0]          count_next;
  logic                   res_valid_reg;
  logic [8*row_width-1:0] res_data_reg;
  logic                   overflow_reg;
  logic                   pop;
  logic                   push;
  logic                   full;
  logic                   drop;

  always_comb begin
    pop        = res_valid_reg && res_ready;
    full       = (count_reg == cw'(fifo_depth));
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    count_next = count_reg + cw'(push) - cw'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= aligned;
  end

  // The head register is refreshed from the array (or the incoming row) so res_data is show-ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      count_reg     <= count_next;
      res_valid_reg <= (count_next != '0);
      if (push) wr_ptr_reg <= wr_ptr_reg + aw'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + aw'(1);
      if (drop) overflow_reg <= 1'b1;
      if (pop) begin
        if (count_reg > cw'(1))
          res_data_reg <= mem[rd_ptr_reg + aw'(1)];
        else if (push)
          res_data_reg <= aligned;
      end else if (push && (count_reg == '0)) begin
        res_data_reg <= aligned;
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_sysarray_result_drain.sv
// Directed bench for sysarray_result_drain: drives skewed column data per cycle
// and compares outputs against hand-computed rows and cycle numbers.
module tb_sysarray_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mac_in;
  logic        start;
  logic [7:0]  num_rows;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_row [4];

  sysarray_result_drain #(.row_width(4), .fifo_depth(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mac_in    (mac_in),
    .start     (start),
    .num_rows  (num_rows),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Column i of row k is driven at relative cycle 1+k+i; pat 0 is 0x11*(i+1), pat 1 is 0x10*k+i.
  function automatic logic [31:0] stim(input int c, input int n, input int pat);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = c - 1 - i;
      if (k >= 0 && k < n) v[8*i +: 8] = (pat == 0) ? 8'(17 * (i + 1)) : 8'(16 * k + i);
    end
    return v;
  endfunction

  initial begin
    exp_row[0] = 32'h03020100;
    exp_row[1] = 32'h13121110;
    exp_row[2] = 32'h23222120;
    exp_row[3] = 32'h33323130;

    // reset with random inputs
    rst = 1'b1; start = 1'b0; num_rows = '0; mac_in = '0; res_ready = 1'b0;
    step();
    mac_in = $urandom; start = 1'($urandom); num_rows = 8'($urandom); res_ready = 1'($urandom);
    step();
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0; start = 1'b0; mac_in = '0; res_ready = 1'b1;
    step();

    // single row
    start = 1'b1; num_rows = 8'd1; mac_in = '0;
    for (int c = 1; c <= 6; c++) begin
      step();
      check($sformatf("t2_busy_c%0d", c), busy, (c <= 4));
      check($sformatf("t2_done_c%0d", c), done, (c == 5));
      if (c == 4) check("t2_valid_c4", res_valid, 0);
      if (c == 5) begin
        check("t2_valid_c5", res_valid, 1);
        check("t2_data_c5", res_data, 32'h44332211);
      end
      if (c == 6) check("t2_valid_c6", res_valid, 0);
      start = 1'b0; mac_in = stim(c, 1, 0);
    end

    // streaming four rows
    start = 1'b1; num_rows = 8'd4; mac_in = '0;
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("t3_busy_c%0d", c), busy, (c <= 7));
      check($sformatf("t3_done_c%0d", c), done, (c == 8));
      check($sformatf("t3_valid_c%0d", c), res_valid, (c >= 5 && c <= 8));
      if (c >= 5 && c <= 8) check($sformatf("t3_data_c%0d", c), res_data, exp_row[c-5]);
      start = 1'b0; mac_in = stim(c, 4, 1);
    end

    // backpressure and overflow
    res_ready = 1'b0;
    start = 1'b1; num_rows = 8'd6; mac_in = '0;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c >= 8) check($sformatf("t4_ovf_c%0d", c), overflow, (c >= 9));
      check($sformatf("t4_done_c%0d", c), done, (c == 10));
      if (c == 5 || c == 11) begin
        check($sformatf("t4_valid_c%0d", c), res_valid, 1);
        check($sformatf("t4_head_c%0d", c), res_data, exp_row[0]);
      end
      if (c >= 12 && c <= 15) begin
        check($sformatf("t4_dvalid_c%0d", c), res_valid, 1);
        check($sformatf("t4_ddata_c%0d", c), res_data, exp_row[c-12]);
      end
      if (c == 16) check("t4_empty_c16", res_valid, 0);
      start = 1'b0; mac_in = stim(c, 6, 1);
      res_ready = (c >= 12);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_ovf_cleared", overflow, 0);
    check("t4_valid_cleared", res_valid, 0);

    // start with zero rows is ignored
    start = 1'b1; num_rows = 8'd0; mac_in = '0;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("t5a_busy_c%0d", c), busy, 0);
      check($sformatf("t5a_valid_c%0d", c), res_valid, 0);
      start = 1'b0;
    end

    // second start during collection is ignored
    start = 1'b1; num_rows = 8'd2; mac_in = '0;
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("t5b_busy_c%0d", c), busy, (c <= 5));
      check($sformatf("t5b_done_c%0d", c), done, (c == 6));
      check($sformatf("t5b_valid_c%0d", c), res_valid, (c == 5 || c == 6));
      if (c == 5 || c == 6) check($sformatf("t5b_data_c%0d", c), res_data, exp_row[c-5]);
      start = (c == 2);
      num_rows = (c == 2) ? 8'd5 : 8'd0;
      mac_in = stim(c, 2, 1);
    end

    // reset in the middle of a collection
    start = 1'b1; num_rows = 8'd4; mac_in = '0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 4) begin
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_data", res_data, 0);
      end
      if (c >= 4) check($sformatf("t6_valid_c%0d", c), res_valid, 0);
      if (c >= 5) check($sformatf("t6_busy_c%0d", c), busy, 0);
      start = 1'b0; mac_in = stim(c, 4, 1);
      rst = (c == 3);
    end
    start = 1'b1; num_rows = 8'd4; mac_in = '0;
    for (int c = 1; c <= 9; c++) begin
      step();
      check($sformatf("t6r_busy_c%0d", c), busy, (c <= 7));
      check($sformatf("t6r_valid_c%0d", c), res_valid, (c >= 5 && c <= 8));
      if (c >= 5 && c <= 8) check($sformatf("t6r_data_c%0d", c), res_data, exp_row[c-5]);
      start = 1'b0; mac_in = stim(c, 4, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
